rtc_display_sequencer: RTL and testbench

Periodically reads date, time and chronometer BCD registers from the RTC bus interface and presents them to the VGA text blocks (date, time, timer digit renderers). Reads are collected into shadow registers and committed atomically during video blanking, so the display never shows a mixed old/new value. Sweeps are suspended while the user is programming, so the edit path owns the bus. Drives okmaquina to enable the digit renderers once valid data exists.

---
 rtl/rtc_display_sequencer_if.sv | 12 +
 rtl/rtc_display_sequencer.sv | 144 ++++++++++++++
 tb/tb_rtc_display_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_display_sequencer_if.sv
// RTC register read bus shared between the display sequencer and the RTC.
interface rtc_display_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [7:0]        rd_data;

    modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
    modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/rtc_display_sequencer.sv
// Sweeps the nine RTC date/time/timer BCD registers once per frame into
// shadow registers and publishes them all at once during video blanking.
module rtc_display_sequencer #(
    parameter int                TIMEOUT    = 64,
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] ADDR_DATE  = 8'h24,
    parameter logic [ADDR_W-1:0] ADDR_TIME  = 8'h21,
    parameter logic [ADDR_W-1:0] ADDR_TIMER = 8'h41
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_frame_tick,
    input  logic                     i_video_on,
    input  logic                     i_programar_on,
    input  logic                     i_bus_busy,
    rtc_display_sequencer_if.master  bus,
    output logic [7:0]               o_fecha_out1,
    output logic [7:0]               o_fecha_out2,
    output logic [7:0]               o_fecha_out3,
    output logic [7:0]               o_hora_out1,
    output logic [7:0]               o_hora_out2,
    output logic [7:0]               o_hora_out3,
    output logic [7:0]               o_crono_out1,
    output logic [7:0]               o_crono_out2,
    output logic [7:0]               o_crono_out3,
    output logic                     o_okmaquina,
    output logic                     o_sweep_done,
    output logic                     o_timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP, S_COMMIT} state_t;

    state_t            r_state;
    logic [3:0]        r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_shadow [0:8];
    logic [7:0]        r_out    [0:8];
    logic              r_rd_req;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_ok;
    logic              r_done;
    logic              r_terr;

    // Date is read ascending (day, month, year); time and timer are read
    // descending so slot order matches hour/minute/second on the outputs.
    function automatic logic [ADDR_W-1:0] f_addr(input logic [3:0] idx);
        logic [ADDR_W-1:0] v;
        if (idx < 4'd3)
            v = ADDR_DATE + ADDR_W'(idx);
        else if (idx < 4'd6)
            v = ADDR_TIME + ADDR_W'(4'd5 - idx);
        else
            v = ADDR_TIMER + ADDR_W'(4'd8 - idx);
        return v;
    endfunction

    // Sweep FSM: request, wait for ack or timeout, one idle gap, then commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
            r_ok      <= 1'b0;
            r_done    <= 1'b0;
            r_terr    <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_shadow[i] <= '0;
                r_out[i]    <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_frame_tick && !i_programar_on && !i_bus_busy) begin
                        r_idx     <= '0;
                        r_cnt     <= '0;
                        r_rd_addr <= f_addr(4'd0);
                        r_rd_req  <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A late ack landing on the last counted cycle still wins.
                    if (bus.rd_ack) begin
                        r_shadow[r_idx] <= bus.rd_data;
                        r_cnt           <= '0;
                        r_rd_req        <= 1'b0;
                        r_state         <= S_GAP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_terr   <= 1'b1;
                        r_cnt    <= '0;
                        r_rd_req <= 1'b0;
                        r_state  <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    // Programming mode is honoured only between transactions.
                    if (i_programar_on) begin
                        r_state <= S_IDLE;
                    end else if (r_idx == 4'd8) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_idx     <= r_idx + 4'd1;
                        r_rd_addr <= f_addr(r_idx + 4'd1);
                        r_rd_req  <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_COMMIT: begin
                    if (i_programar_on) begin
                        r_state <= S_IDLE;
                    end else if (!i_video_on) begin
                        for (int i = 0; i < 9; i++)
                            r_out[i] <= r_shadow[i];
                        r_ok    <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_req    = r_rd_req;
    assign bus.rd_addr   = r_rd_addr;
    assign o_fecha_out1  = r_out[0];
    assign o_fecha_out2  = r_out[1];
    assign o_fecha_out3  = r_out[2];
    assign o_hora_out1   = r_out[3];
    assign o_hora_out2   = r_out[4];
    assign o_hora_out3   = r_out[5];
    assign o_crono_out1  = r_out[6];
    assign o_crono_out2  = r_out[7];
    assign o_crono_out3  = r_out[8];
    assign o_okmaquina   = r_ok;
    assign o_sweep_done  = r_done;
    assign o_timeout_err = r_terr;
endmodule

// File: tb/tb_rtc_display_sequencer.sv
// Directed bench for rtc_display_sequencer with an RTC bus responder model.
module tb_rtc_display_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic frame_tick, video_on, programar_on, bus_busy;
    logic [7:0] f1, f2, f3, h1, h2, h3, c1, c2, c3;
    logic okm, sdone, terr;
    logic [71:0] w_outs;

    rtc_display_sequencer_if #(.ADDR_W(8)) bus ();

    rtc_display_sequencer dut (
        .clk(clk), .reset(reset),
        .i_frame_tick(frame_tick), .i_video_on(video_on),
        .i_programar_on(programar_on), .i_bus_busy(bus_busy),
        .bus(bus),
        .o_fecha_out1(f1), .o_fecha_out2(f2), .o_fecha_out3(f3),
        .o_hora_out1(h1), .o_hora_out2(h2), .o_hora_out3(h3),
        .o_crono_out1(c1), .o_crono_out2(c2), .o_crono_out3(c3),
        .o_okmaquina(okm), .o_sweep_done(sdone), .o_timeout_err(terr)
    );

    assign w_outs = {f1, f2, f3, h1, h2, h3, c1, c2, c3};

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    int         delay_mem [256];   // 0 = never ack
    int addr_log[$];
    int len_log[$];
    int gap_log[$];
    int done_cnt = 0;
    int addr_glitch = 0;

    // Responder: samples 1 time unit after each rising edge, acks after delay.
    initial begin
        int high_cnt, low_cnt, cur_addr;
        bit prev_req;
        high_cnt = 0; low_cnt = 0; cur_addr = 0; prev_req = 0;
        bus.rd_ack = 1'b0;
        bus.rd_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus.rd_ack = 1'b0;
            if (bus.rd_req === 1'b1) begin
                if (!prev_req) begin
                    addr_log.push_back(int'(bus.rd_addr));
                    gap_log.push_back(low_cnt);
                    cur_addr = int'(bus.rd_addr);
                    high_cnt = 0;
                end else if (int'(bus.rd_addr) != cur_addr) begin
                    addr_glitch++;
                end
                high_cnt++;
                low_cnt = 0;
                if (delay_mem[bus.rd_addr] != 0 && high_cnt == delay_mem[bus.rd_addr]) begin
                    bus.rd_ack = 1'b1;
                    bus.rd_data = mem[bus.rd_addr];
                end
            end else begin
                if (prev_req) len_log.push_back(high_cnt);
                low_cnt++;
            end
            if (sdone === 1'b1) done_cnt++;
            prev_req = (bus.rd_req === 1'b1);
        end
    end

    task automatic clear_logs();
        addr_log.delete(); len_log.delete(); gap_log.delete();
        addr_glitch = 0;
    endtask

    task automatic set_mem(input logic [71:0] v);
        mem[8'h24] = v[71:64]; mem[8'h25] = v[63:56]; mem[8'h26] = v[55:48];
        mem[8'h23] = v[47:40]; mem[8'h22] = v[39:32]; mem[8'h21] = v[31:24];
        mem[8'h43] = v[23:16]; mem[8'h42] = v[15:8];  mem[8'h41] = v[7:0];
    endtask

    task automatic tick();
        @(posedge clk); #2; frame_tick = 1'b1;
        @(posedge clk); #2; frame_tick = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #2;
            if (sdone === 1'b1) got = 1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2; reset = 1'b0;
        @(posedge clk); #2; reset = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (bus.rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got=%b exp=0", bus.rd_req); end
        checks++; if (w_outs !== 72'h0) begin errors++; $display("FAIL reset_outs got=%h exp=0", w_outs); end
        checks++; if (okm !== 1'b0) begin errors++; $display("FAIL reset_okmaquina got=%b exp=0", okm); end
        checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL reset_sweep_done got=%b exp=0", sdone); end
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", terr); end
    endtask

    task automatic test_basic_sweep();
        bit got;
        logic [71:0] addrs;
        int bad_gap, bad_len, d0;
        clear_logs();
        set_mem(72'h150924_134507_000230);
        video_on = 1'b0;
        d0 = done_cnt;
        tick();
        wait_done(200, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", got); end
        addrs = '0;
        for (int i = 0; i < addr_log.size() && i < 9; i++) addrs = {addrs[63:0], 8'(addr_log[i])};
        checks++; if (addr_log.size() != 9 || addrs !== 72'h242526_232221_434241) begin
            errors++; $display("FAIL basic_addr_seq got=%h n=%0d exp=242526232221434241", addrs, addr_log.size()); end
        bad_gap = 0;
        for (int i = 1; i < gap_log.size(); i++) if (gap_log[i] != 1) bad_gap++;
        checks++; if (gap_log.size() != 9 || bad_gap != 0) begin
            errors++; $display("FAIL basic_gap bad=%0d n=%0d exp=0 bad of 9", bad_gap, gap_log.size()); end
        bad_len = 0;
        for (int i = 0; i < len_log.size(); i++) if (len_log[i] != 3) bad_len++;
        checks++; if (len_log.size() != 9 || bad_len != 0) begin
            errors++; $display("FAIL basic_req_len bad=%0d n=%0d exp=0 bad of 9", bad_len, len_log.size()); end
        checks++; if (addr_glitch != 0) begin errors++; $display("FAIL basic_addr_stable got=%0d exp=0", addr_glitch); end
        checks++; if (w_outs !== 72'h150924_134507_000230) begin
            errors++; $display("FAIL basic_outs got=%h exp=150924134507000230", w_outs); end
        checks++; if (okm !== 1'b1) begin errors++; $display("FAIL basic_okmaquina got=%b exp=1", okm); end
        @(posedge clk); #2;
        checks++; if (sdone !== 1'b0 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL basic_done_pulse got=%b cnt=%0d exp=0 cnt=1", sdone, done_cnt - d0); end
    endtask

    task automatic test_video_blank();
        int bad, i;
        clear_logs();
        set_mem(72'h161025_144608_010331);
        video_on = 1'b1;
        tick();
        i = 0;
        while (len_log.size() < 9 && i < 100) begin @(posedge clk); #2; i++; end
        checks++; if (len_log.size() < 9) begin errors++; $display("FAIL video_reads got=%0d exp=9", len_log.size()); end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            if (w_outs !== 72'h150924_134507_000230 || sdone !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL video_hold bad_cycles=%0d exp=0 outs=%h", bad, w_outs); end
        video_on = 1'b0;
        @(posedge clk); #2;
        checks++; if (w_outs !== 72'h161025_144608_010331 || sdone !== 1'b1) begin
            errors++; $display("FAIL video_commit got=%h done=%b exp=161025144608010331 done=1", w_outs, sdone); end
    endtask

    task automatic test_timeout();
        bit got;
        clear_logs();
        set_mem(72'h150924_135907_000230);
        delay_mem[8'h22] = 0;
        tick();
        wait_done(300, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL timeout_done got=%b exp=1", got); end
        checks++; if (len_log.size() < 5 || len_log[4] != 64) begin
            errors++; $display("FAIL timeout_req_len got=%0d exp=64", (len_log.size() < 5) ? -1 : len_log[4]); end
        checks++; if (terr !== 1'b1) begin errors++; $display("FAIL timeout_err got=%b exp=1", terr); end
        checks++; if (w_outs !== 72'h150924_134607_000230) begin
            errors++; $display("FAIL timeout_outs got=%h exp=150924134607000230", w_outs); end
        delay_mem[8'h22] = 3;
    endtask

    task automatic test_ack_at_limit();
        bit got;
        do_reset();
        clear_logs();
        set_mem(72'h150924_133307_000230);
        delay_mem[8'h22] = 64;
        tick();
        wait_done(300, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL limit_done got=%b exp=1", got); end
        checks++; if (len_log.size() < 5 || len_log[4] != 64) begin
            errors++; $display("FAIL limit_req_len got=%0d exp=64", (len_log.size() < 5) ? -1 : len_log[4]); end
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL limit_timeout_err got=%b exp=0", terr); end
        checks++; if (w_outs !== 72'h150924_133307_000230) begin
            errors++; $display("FAIL limit_outs got=%h exp=150924133307000230", w_outs); end
        delay_mem[8'h22] = 3;
    endtask

    task automatic test_bus_busy();
        clear_logs();
        bus_busy = 1'b1;
        tick();
        bus_busy = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        checks++; if (addr_log.size() != 0) begin
            errors++; $display("FAIL busy_drop got=%0d requests exp=0", addr_log.size()); end
    endtask

    task automatic test_program_abort();
        int d0, i;
        clear_logs();
        set_mem(72'h311299_235958_011005);
        d0 = done_cnt;
        tick();
        i = 0;
        while (addr_log.size() < 3 && i < 50) begin @(posedge clk); #2; i++; end
        programar_on = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        checks++; if (addr_log.size() != 3 || len_log.size() != 3) begin
            errors++; $display("FAIL abort_req_count got=%0d/%0d exp=3/3", addr_log.size(), len_log.size()); end
        checks++; if (len_log.size() < 3 || len_log[2] != 3) begin
            errors++; $display("FAIL abort_last_completes got=%0d exp=3", (len_log.size() < 3) ? -1 : len_log[2]); end
        checks++; if (done_cnt != d0 || w_outs !== 72'h150924_133307_000230) begin
            errors++; $display("FAIL abort_no_commit got=%h done=%0d exp=150924133307000230 done=0", w_outs, done_cnt - d0); end
        tick();
        repeat (10) @(posedge clk);
        #2;
        checks++; if (addr_log.size() != 3) begin
            errors++; $display("FAIL abort_tick_blocked got=%0d exp=3", addr_log.size()); end
        programar_on = 1'b0;
    endtask

    task automatic test_async_reset();
        bit got;
        int i;
        clear_logs();
        tick();
        i = 0;
        while (addr_log.size() < 1 && i < 20) begin @(posedge clk); #2; i++; end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.rd_req !== 1'b0 || okm !== 1'b0) begin
            errors++; $display("FAIL async_rd_req got=%b ok=%b exp=0 ok=0", bus.rd_req, okm); end
        checks++; if (w_outs !== 72'h0) begin errors++; $display("FAIL async_outs got=%h exp=0", w_outs); end
        @(posedge clk); #2;
        reset = 1'b1;
        clear_logs();
        tick();
        wait_done(200, got);
        checks++; if (got !== 1'b1 || addr_log.size() < 1 || addr_log[0] != 8'h24) begin
            errors++; $display("FAIL async_restart got=%b first=%0h exp=1 first=24", got, (addr_log.size() < 1) ? 0 : addr_log[0]); end
        checks++; if (w_outs !== 72'h311299_235958_011005 || okm !== 1'b1) begin
            errors++; $display("FAIL async_outs_after got=%h ok=%b exp=311299235958011005 ok=1", w_outs, okm); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin mem[a] = 8'h00; delay_mem[a] = 3; end
        reset = 1'b0;
        frame_tick = 1'b0; video_on = 1'b0; programar_on = 1'b0; bus_busy = 1'b0;
        #23;
        test_reset();
        reset = 1'b1;
        test_basic_sweep();
        test_video_blank();
        test_timeout();
        test_ack_at_limit();
        test_bus_busy();
        test_program_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
